// File: rtl/nvme_admin_sq_feeder.sv
// nvme_admin_sq_feeder
//   Pops one admin request at a time from an upstream FIFO, expands it into a
//   64-byte NVMe submission queue entry, writes that entry dword by dword into
//   the SQ ring slot at the current tail, then requests a tail doorbell.
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   fifo_q          : admin request word (valid the cycle after fifo_rdreq)
//   fifo_rdempty    : upstream FIFO empty
//   fifo_rdreq      : one-cycle pop strobe
//   sq_head         : SQ head pointer from the completion path
//   sq_wr_valid/ready, sq_wr_addr, sq_wr_data : dword write channel
//   db_valid/ready, db_tail : tail doorbell request channel
//   sq_tail         : current committed tail
//   busy            : high whenever a command is in progress
module nvme_admin_sq_feeder #(
  parameter int unsigned WIDTH    = 170,
  parameter int unsigned SQ_DEPTH = 32,
  parameter logic [31:0] SQ_BASE  = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            fifo_q,
  input  logic                        fifo_rdempty,
  output logic                        fifo_rdreq,
  input  logic [$clog2(SQ_DEPTH)-1:0] sq_head,
  output logic                        sq_wr_valid,
  input  logic                        sq_wr_ready,
  output logic [31:0]                 sq_wr_addr,
  output logic [31:0]                 sq_wr_data,
  output logic                        db_valid,
  input  logic                        db_ready,
  output logic [$clog2(SQ_DEPTH)-1:0] db_tail,
  output logic [$clog2(SQ_DEPTH)-1:0] sq_tail,
  output logic                        busy
);

  localparam int unsigned AW = $clog2(SQ_DEPTH);

  typedef enum logic [2:0] {IDLE, POP, CAPTURE, WRITE, DOORBELL} state_t;

  state_t         state;
  logic [3:0]     idx;
  logic [15:0]    cid;
  logic [7:0]     opcode;
  logic [31:0]    nsid;
  logic [63:0]    prp1;
  logic [31:0]    cdw10;
  logic [31:0]    cdw11;

  logic [AW-1:0]  tail_next;
  logic           sq_full;
  logic           unused_hi;

  // Top request bits carry no SQE field.
  assign unused_hi = ^fifo_q[WIDTH-1:168];

  // Power-of-two depth: natural AW-bit wrap gives the modulo.
  assign tail_next = sq_tail + AW'(1);
  assign sq_full   = (tail_next == sq_head);

  function automatic logic [31:0] sqe_dword(
    input logic [3:0]  i,
    input logic [15:0] c,
    input logic [7:0]  op,
    input logic [31:0] ns,
    input logic [63:0] prp,
    input logic [31:0] d10,
    input logic [31:0] d11
  );
    logic [31:0] dw;
    case (i)
      4'd0:    dw = {c, 2'b00, 4'b0000, 2'b00, op};
      4'd1:    dw = ns;
      4'd6:    dw = prp[31:0];
      4'd7:    dw = prp[63:32];
      4'd10:   dw = d10;
      4'd11:   dw = d11;
      default: dw = '0;
    endcase
    return dw;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cid         <= '0;
      opcode      <= '0;
      nsid        <= '0;
      prp1        <= '0;
      cdw10       <= '0;
      cdw11       <= '0;
      sq_tail     <= '0;
      fifo_rdreq  <= 1'b0;
      sq_wr_valid <= 1'b0;
      sq_wr_addr  <= '0;
      sq_wr_data  <= '0;
      db_valid    <= 1'b0;
      db_tail     <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_rdempty && !sq_full) begin
            state      <= POP;
            fifo_rdreq <= 1'b1;
            busy       <= 1'b1;
          end
        end
        POP: begin
          fifo_rdreq <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          opcode      <= fifo_q[7:0];
          nsid        <= fifo_q[39:8];
          prp1        <= fifo_q[103:40];
          cdw10       <= fifo_q[135:104];
          cdw11       <= fifo_q[167:136];
          idx         <= '0;
          sq_wr_valid <= 1'b1;
          sq_wr_addr  <= SQ_BASE + (32'(sq_tail) << 6);
          // First dword comes straight from the request so WRITE starts
          // without a bubble.
          sq_wr_data  <= sqe_dword(4'd0, cid, fifo_q[7:0], fifo_q[39:8],
                                   fifo_q[103:40], fifo_q[135:104], fifo_q[167:136]);
          state       <= WRITE;
        end
        WRITE: begin
          if (sq_wr_valid && sq_wr_ready) begin
            if (idx == 4'd15) begin
              sq_wr_valid <= 1'b0;
              sq_tail     <= tail_next;
              db_tail     <= tail_next;
              db_valid    <= 1'b1;
              state       <= DOORBELL;
            end else begin
              idx        <= idx + 4'd1;
              sq_wr_addr <= sq_wr_addr + 32'd4;
              sq_wr_data <= sqe_dword(idx + 4'd1, cid, opcode, nsid, prp1, cdw10, cdw11);
            end
          end
        end
        DOORBELL: begin
          if (db_ready) begin
            db_valid <= 1'b0;
            cid      <= cid + 16'd1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
